// File: rtl/ddr3_wr_burst_ctrl.sv
// Write-side DDR3 burst controller: drains fixed-length bursts of 128-bit words from the
// write FIFO into the DDR3 user interface while walking a linear frame-buffer address window.
module ddr3_wr_burst_ctrl #(
    parameter int                BURST_LEN  = 64,
    parameter int                ADDR_W     = 28,
    parameter logic [ADDR_W-1:0] ADDR_BEGIN = '0,
    parameter logic [ADDR_W-1:0] ADDR_END   = 28'd1_228_800
) (
    input  logic              ui_clk,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic              wr_load,
    input  logic [9:0]        wfifo_rcount,
    input  logic [127:0]      wfifo_dout,
    output logic              wfifo_rden,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic              app_wdf_wren,
    output logic [127:0]      app_wdf_data,
    output logic              app_wdf_end,
    output logic              wr_burst_done
);

    localparam logic [9:0]        BL   = 10'(BURST_LEN);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(8);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [9:0]        r_cmd_cnt;
    logic [9:0]        r_data_cnt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_load_s1;
    logic              r_load_s2;
    logic              r_load_s3;
    logic              r_load_pending;
    logic              r_burst_done;

    logic              w_in_write;
    logic              w_cmd_active;
    logic              w_data_active;
    logic              w_cmd_acc;
    logic              w_data_wr;
    logic              w_start;
    logic              w_load_edge;
    logic [9:0]        w_cmd_cnt_nxt;
    logic [9:0]        w_data_cnt_nxt;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_in_write     = (r_state == WRITE);
    assign w_cmd_active   = w_in_write && (r_cmd_cnt < BL);
    assign w_data_active  = w_in_write && (r_data_cnt < BL);
    assign w_cmd_acc      = w_cmd_active && app_rdy;
    assign w_data_wr      = w_data_active && app_wdf_rdy;
    assign w_cmd_cnt_nxt  = r_cmd_cnt + {9'd0, w_cmd_acc};
    assign w_data_cnt_nxt = r_data_cnt + {9'd0, w_data_wr};
    assign w_load_edge    = r_load_s2 && !r_load_s3;
    assign w_addr_inc     = r_wr_addr + STEP;

    // A pending frame-start must re-base the address before another burst may begin.
    assign w_start = (r_state == IDLE) && init_calib_complete &&
                     (wfifo_rcount >= BL) && !r_load_pending;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Leaving on the post-acceptance counts keeps a full-rate burst at exactly BURST_LEN cycles.
    always_comb begin
        w_next_state  = r_state;
        app_en        = 1'b0;
        app_cmd       = 3'b000;
        app_addr      = r_wr_addr;
        app_wdf_wren  = 1'b0;
        wfifo_rden    = 1'b0;
        app_wdf_end   = 1'b0;
        app_wdf_data  = wfifo_dout;
        wr_burst_done = r_burst_done;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                app_en       = w_cmd_active;
                app_wdf_wren = w_data_wr;
                wfifo_rden   = w_data_wr;
                app_wdf_end  = w_data_wr;
                if ((w_cmd_cnt_nxt == BL) && (w_data_cnt_nxt == BL)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_cnt  <= '0;
            r_data_cnt <= '0;
        end else if (w_start) begin
            r_cmd_cnt  <= '0;
            r_data_cnt <= '0;
        end else begin
            r_cmd_cnt  <= w_cmd_cnt_nxt;
            r_data_cnt <= w_data_cnt_nxt;
        end
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= ADDR_BEGIN;
        end else if (w_cmd_acc) begin
            r_wr_addr <= (w_addr_inc == ADDR_END) ? ADDR_BEGIN : w_addr_inc;
        end else if ((r_state == IDLE) && r_load_pending) begin
            r_wr_addr <= ADDR_BEGIN;
        end
    end

    // wr_load crosses from the source domain: two synchronizer stages plus one for edge detect.
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_s1      <= 1'b0;
            r_load_s2      <= 1'b0;
            r_load_s3      <= 1'b0;
            r_load_pending <= 1'b0;
        end else begin
            r_load_s1 <= wr_load;
            r_load_s2 <= r_load_s1;
            r_load_s3 <= r_load_s2;
            if (w_load_edge) begin
                r_load_pending <= 1'b1;
            end else if (r_state == IDLE) begin
                r_load_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= w_in_write && (w_next_state == IDLE);
        end
    end

endmodule

// File: tb/tb_ddr3_wr_burst_ctrl.sv
// Bench for ddr3_wr_burst_ctrl: a queue-based FIFO feeds random words, and a transaction-level
// model tracks the expected address walk and data order across directed burst scenarios.
module tb_ddr3_wr_burst_ctrl;

    localparam int TB_BL     = 64;
    localparam int TB_BEGIN  = 0;
    localparam int TB_END    = 1024;
    localparam int TB_REGION = TB_END - TB_BEGIN;

    logic         ui_clk = 1'b0;
    logic         rst_n;
    logic         init_calib_complete;
    logic         wr_load;
    logic [9:0]   wfifo_rcount;
    logic [127:0] wfifo_dout;
    logic         wfifo_rden;
    logic         app_rdy;
    logic         app_wdf_rdy;
    logic         app_en;
    logic [2:0]   app_cmd;
    logic [27:0]  app_addr;
    logic         app_wdf_wren;
    logic [127:0] app_wdf_data;
    logic         app_wdf_end;
    logic         wr_burst_done;

    ddr3_wr_burst_ctrl #(
        .BURST_LEN (TB_BL),
        .ADDR_W    (28),
        .ADDR_BEGIN(28'd0),
        .ADDR_END  (28'd1024)
    ) dut (
        .ui_clk             (ui_clk),
        .rst_n              (rst_n),
        .init_calib_complete(init_calib_complete),
        .wr_load            (wr_load),
        .wfifo_rcount       (wfifo_rcount),
        .wfifo_dout         (wfifo_dout),
        .wfifo_rden         (wfifo_rden),
        .app_rdy            (app_rdy),
        .app_wdf_rdy        (app_wdf_rdy),
        .app_en             (app_en),
        .app_cmd            (app_cmd),
        .app_addr           (app_addr),
        .app_wdf_wren       (app_wdf_wren),
        .app_wdf_data       (app_wdf_data),
        .app_wdf_end        (app_wdf_end),
        .wr_burst_done      (wr_burst_done)
    );

    always #5 ui_clk = ~ui_clk;

    int           total;
    int           bad;
    int           cycNum;
    int           rdyMode;
    logic [127:0] fifoQ[$];
    logic [127:0] expQ[$];
    int           expAddr;
    bit           loadReq;
    int           cmdInBurst;
    int           burstCmds, burstData, enCycles, doneCnt;
    int           firstEnCyc, lastEnCyc, doneCyc, lastCmdCyc, lastDataCyc;
    logic [27:0]  firstAddr, lastAddr;
    int           pushCyc;
    int           guard;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void updateFifoDrive();
        wfifo_rcount = 10'(fifoQ.size());
        wfifo_dout   = (fifoQ.size() > 0) ? fifoQ[0] : 128'd0;
    endfunction

    task automatic applyStimulus(input int n);
        logic [127:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            fifoQ.push_back(w);
            expQ.push_back(w);
        end
        updateFifoDrive();
    endtask

    task automatic clearBurstStats();
        burstCmds   = 0;
        burstData   = 0;
        enCycles    = 0;
        doneCnt     = 0;
        firstEnCyc  = -1;
        lastEnCyc   = -1;
        doneCyc     = -1;
        lastCmdCyc  = -1;
        lastDataCyc = -1;
    endtask

    // One clock: drive readies, observe at the falling edge, then let the FIFO pop after the rising edge.
    task automatic tick();
        logic         sampledRden;
        logic [127:0] expWord;
        case (rdyMode)
            1:       begin app_rdy = 1'(cycNum % 2); app_wdf_rdy = 1'b1; end
            2:       begin app_rdy = ($urandom_range(0, 3) != 0); app_wdf_rdy = ($urandom_range(0, 3) != 0); end
            default: begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
        endcase
        @(negedge ui_clk);
        if (app_en === 1'b1) begin
            if (enCycles == 0) firstEnCyc = cycNum;
            lastEnCyc = cycNum;
            enCycles++;
        end
        if (app_en === 1'b1 && app_rdy === 1'b1) begin
            if (cmdInBurst == 0 && loadReq) begin
                expAddr = TB_BEGIN;
                loadReq = 1'b0;
            end
            checkOutput("cmd_addr", 128'(app_addr), 128'(expAddr));
            if (cmdInBurst == 0) firstAddr = app_addr;
            lastAddr   = app_addr;
            expAddr    = TB_BEGIN + ((expAddr - TB_BEGIN + 8) % TB_REGION);
            cmdInBurst = (cmdInBurst + 1) % TB_BL;
            burstCmds++;
            lastCmdCyc = cycNum;
        end
        if (app_wdf_wren === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("wr_spurious", 128'(app_wdf_wren), 128'd0);
            end else begin
                expWord = expQ.pop_front();
                checkOutput("wr_data", app_wdf_data, expWord);
            end
            checkOutput("wr_end", 128'(app_wdf_end), 128'd1);
            checkOutput("wr_rden", 128'(wfifo_rden), 128'd1);
            burstData++;
            lastDataCyc = cycNum;
        end
        if (wr_burst_done === 1'b1) begin
            doneCnt++;
            doneCyc = cycNum;
        end
        sampledRden = wfifo_rden;
        @(posedge ui_clk);
        #1;
        if (sampledRden === 1'b1 && fifoQ.size() > 0) void'(fifoQ.pop_front());
        updateFifoDrive();
        cycNum++;
    endtask

    task automatic runBurst(input string tag, input int expFirst, input bit consec,
                            input int dropCalibAt, input int loadAt);
        int budget;
        bit dropped;
        bit loaded;
        int lastEvt;
        budget  = 0;
        dropped = 1'b0;
        loaded  = 1'b0;
        while (doneCnt == 0 && budget < 1000) begin
            tick();
            budget++;
            if (dropCalibAt >= 0 && !dropped && burstCmds >= dropCalibAt) begin
                init_calib_complete = 1'b0;
                dropped = 1'b1;
            end
            if (loadAt >= 0 && !loaded && burstCmds >= loadAt) begin
                wr_load = 1'b1;
                loadReq = 1'b1;
                loaded  = 1'b1;
            end
        end
        checkOutput({tag, "_done_seen"}, 128'(doneCnt > 0), 128'd1);
        repeat (3) tick();
        lastEvt = (lastCmdCyc > lastDataCyc) ? lastCmdCyc : lastDataCyc;
        checkOutput({tag, "_cmds"}, 128'(burstCmds), 128'(TB_BL));
        checkOutput({tag, "_data"}, 128'(burstData), 128'(TB_BL));
        checkOutput({tag, "_done_cnt"}, 128'(doneCnt), 128'd1);
        checkOutput({tag, "_done_time"}, 128'(doneCyc), 128'(lastEvt + 1));
        checkOutput({tag, "_first_addr"}, 128'(firstAddr), 128'(expFirst));
        checkOutput({tag, "_last_addr"}, 128'(lastAddr),
                    128'(TB_BEGIN + ((expFirst - TB_BEGIN + (TB_BL - 1) * 8) % TB_REGION)));
        if (consec) begin
            checkOutput({tag, "_en_cycles"}, 128'(enCycles), 128'(TB_BL));
            checkOutput({tag, "_en_span"}, 128'(lastEnCyc - firstEnCyc + 1), 128'(TB_BL));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cycNum = 0;
        rdyMode = 0;
        expAddr = TB_BEGIN;
        loadReq = 1'b0;
        cmdInBurst = 0;
        firstAddr = '0;
        lastAddr = '0;
        rst_n = 1'b0;
        init_calib_complete = 1'b0;
        wr_load = 1'b0;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        clearBurstStats();
        updateFifoDrive();

        #2;
        checkOutput("rst_app_en", 128'(app_en), 128'd0);
        checkOutput("rst_wren", 128'(app_wdf_wren), 128'd0);
        checkOutput("rst_wdf_end", 128'(app_wdf_end), 128'd0);
        checkOutput("rst_rden", 128'(wfifo_rden), 128'd0);
        checkOutput("rst_done", 128'(wr_burst_done), 128'd0);
        checkOutput("rst_addr", 128'(app_addr), 128'd0);
        checkOutput("rst_cmd", 128'(app_cmd), 128'd0);
        @(negedge ui_clk);
        @(negedge ui_clk);
        rst_n = 1'b1;
        @(posedge ui_clk);
        #1;

        // Full FIFO with calibration pending, then a full-rate burst.
        clearBurstStats();
        applyStimulus(TB_BL);
        repeat (10) tick();
        checkOutput("calib_off_en", 128'(enCycles), 128'd0);
        checkOutput("calib_off_wr", 128'(burstData), 128'd0);
        init_calib_complete = 1'b1;
        runBurst("b1", 0, 1'b1, -1, -1);
        checkOutput("b1_rcount", 128'(wfifo_rcount), 128'd0);

        // One word short of a burst, then the final word.
        clearBurstStats();
        applyStimulus(TB_BL - 1);
        repeat (10) tick();
        checkOutput("cnt63_no_en", 128'(enCycles), 128'd0);
        applyStimulus(1);
        pushCyc = cycNum;
        runBurst("b2", 512, 1'b1, -1, -1);
        checkOutput("b2_start_lat", 128'((firstEnCyc - pushCyc) <= 2), 128'd1);

        // Command channel throttled: address wraps 1016 -> 0 and data finishes first.
        rdyMode = 1;
        clearBurstStats();
        applyStimulus(TB_BL);
        runBurst("b3", 0, 1'b0, -1, -1);
        checkOutput("b3_data_first", 128'(lastDataCyc < lastCmdCyc), 128'd1);
        rdyMode = 0;

        // Frame start mid-burst: burst completes, next burst re-bases.
        clearBurstStats();
        applyStimulus(TB_BL);
        runBurst("b4", 512, 1'b1, -1, 25);
        wr_load = 1'b0;

        // Random readies with calibration lost mid-burst.
        rdyMode = 2;
        clearBurstStats();
        applyStimulus(2 * TB_BL);
        runBurst("b5", 0, 1'b0, 10, -1);
        clearBurstStats();
        repeat (10) tick();
        checkOutput("calib_low_no_start", 128'(enCycles), 128'd0);
        checkOutput("calib_low_rcount", 128'(wfifo_rcount), 128'(TB_BL));

        // Frame start while idle: address re-bases 3 to 4 cycles later.
        wr_load = 1'b1;
        repeat (2) tick();
        checkOutput("load_lat_min", 128'(app_addr), 128'(expAddr));
        repeat (2) tick();
        checkOutput("load_lat_max", 128'(app_addr), 128'(TB_BEGIN));
        expAddr = TB_BEGIN;
        wr_load = 1'b0;

        clearBurstStats();
        init_calib_complete = 1'b1;
        runBurst("b6", 0, 1'b0, -1, -1);

        // Reset pulsed in the middle of a burst.
        rdyMode = 0;
        clearBurstStats();
        applyStimulus(TB_BL);
        guard = 0;
        while (burstCmds < 10 && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("b7_started", 128'(burstCmds >= 10), 128'd1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_app_en", 128'(app_en), 128'd0);
        checkOutput("midrst_wren", 128'(app_wdf_wren), 128'd0);
        checkOutput("midrst_rden", 128'(wfifo_rden), 128'd0);
        checkOutput("midrst_wdf_end", 128'(app_wdf_end), 128'd0);
        checkOutput("midrst_done", 128'(wr_burst_done), 128'd0);
        checkOutput("midrst_addr", 128'(app_addr), 128'd0);
        fifoQ.delete();
        expQ.delete();
        updateFifoDrive();
        @(negedge ui_clk);
        rst_n = 1'b1;
        @(posedge ui_clk);
        #1;
        cmdInBurst = 0;
        expAddr = TB_BEGIN;
        loadReq = 1'b0;
        clearBurstStats();
        repeat (5) tick();
        checkOutput("post_rst_addr", 128'(app_addr), 128'd0);
        checkOutput("post_rst_idle", 128'(enCycles), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
